multicycle_decoder: RTL and testbench

- Control FSM and instruction decoder for the multicycle ARMv4 datapath.
- Decodes Op, Funct and Rd of the latched instruction.
- Sequences the fetch/decode/execute/memory/writeback steps.
- Produces the unconditioned write requests (PCS, NextPC, RegW, MemW, FlagW) that the downstream condition-gating logic qualifies with the condition result. It also drives all datapath mux selects and the ALU command.

---
 rtl/multicycle_decoder.sv | 167 ++++++++++++++++
 tb/tb_multicycle_decoder.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/multicycle_decoder.sv
// Control FSM and instruction decoder for the multicycle ARMv4 datapath.
// Sequences fetch/decode/execute/memory/writeback, drives datapath selects
// and the ALU command, and raises unconditioned write requests that the
// downstream condition logic qualifies.
module multicycle_decoder #(
  parameter int unsigned STATE_W = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] Op,
  input  logic [5:0] Funct,
  input  logic [3:0] Rd,
  output logic       PCS,
  output logic       NextPC,
  output logic       RegW,
  output logic       MemW,
  output logic [1:0] FlagW,
  output logic       IRWrite,
  output logic       AdrSrc,
  output logic [1:0] ResultSrc,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ImmSrc,
  output logic [1:0] RegSrc,
  output logic [1:0] ALUControl
);

  typedef enum logic [STATE_W-1:0] {
    FETCH,
    DECODE,
    MEMADR,
    MEMRD,
    MEMWB,
    MEMWR,
    EXECR,
    EXECI,
    ALUWB,
    BRANCH
  } state_t;

  state_t state;
  state_t next_state;

  // Ungated Moore write strobes; reset qualifies them below.
  logic       ir_write_raw;
  logic       next_pc_raw;
  logic       reg_w_raw;
  logic       mem_w_raw;
  logic       branch_raw;
  logic       alu_op;
  logic [1:0] flag_w_raw;

  // State register; reset abandons the current instruction and returns to FETCH.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= FETCH;
    end else begin
      state <= next_state;
    end
  end

  // Instruction sequencing.
  always_comb begin
    next_state = FETCH;
    unique case (state)
      FETCH:  next_state = DECODE;
      DECODE: begin
        unique case (Op)
          2'b01:   next_state = MEMADR;
          2'b00:   next_state = Funct[5] ? EXECI : EXECR;
          2'b10:   next_state = BRANCH;
          default: next_state = FETCH;
        endcase
      end
      MEMADR: next_state = Funct[0] ? MEMRD : MEMWR;
      MEMRD:  next_state = MEMWB;
      MEMWB:  next_state = FETCH;
      MEMWR:  next_state = FETCH;
      EXECR:  next_state = ALUWB;
      EXECI:  next_state = ALUWB;
      ALUWB:  next_state = FETCH;
      BRANCH: next_state = FETCH;
      default: next_state = FETCH;
    endcase
  end

  // Per-state datapath selects and raw write strobes.
  always_comb begin
    ir_write_raw = 1'b0;
    next_pc_raw  = 1'b0;
    reg_w_raw    = 1'b0;
    mem_w_raw    = 1'b0;
    branch_raw   = 1'b0;
    alu_op       = 1'b0;
    AdrSrc       = 1'b0;
    ResultSrc    = 2'b00;
    ALUSrcA      = 1'b0;
    ALUSrcB      = 2'b00;
    unique case (state)
      FETCH: begin
        ALUSrcA      = 1'b1;
        ALUSrcB      = 2'b10;
        ResultSrc    = 2'b10;
        ir_write_raw = 1'b1;
        next_pc_raw  = 1'b1;
      end
      DECODE: begin
        ALUSrcA   = 1'b1;
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
      end
      MEMADR: ALUSrcB = 2'b01;
      MEMRD:  AdrSrc = 1'b1;
      MEMWB: begin
        ResultSrc = 2'b01;
        reg_w_raw = 1'b1;
      end
      MEMWR: begin
        AdrSrc    = 1'b1;
        mem_w_raw = 1'b1;
      end
      EXECR: alu_op = 1'b1;
      EXECI: begin
        ALUSrcB = 2'b01;
        alu_op  = 1'b1;
      end
      ALUWB: reg_w_raw = 1'b1;
      BRANCH: begin
        ALUSrcB    = 2'b01;
        ResultSrc  = 2'b10;
        branch_raw = 1'b1;
      end
      default: ;
    endcase
  end

  // ALU command and flag-write decode; unrecognised commands add without flags.
  always_comb begin
    logic known;
    logic add_sub;
    known      = 1'b1;
    add_sub    = 1'b0;
    ALUControl = 2'b00;
    if (alu_op) begin
      unique case (Funct[4:1])
        4'b0100: begin ALUControl = 2'b00; add_sub = 1'b1; end
        4'b0010: begin ALUControl = 2'b01; add_sub = 1'b1; end
        4'b0000: ALUControl = 2'b10;
        4'b1100: ALUControl = 2'b11;
        default: known = 1'b0;
      endcase
    end
    flag_w_raw = (alu_op && known) ? {Funct[0], Funct[0] & add_sub} : 2'b00;
  end

  // Reset masks every write request combinationally so nothing writes while held.
  assign IRWrite = ir_write_raw & reset;
  assign NextPC  = next_pc_raw & reset;
  assign RegW    = reg_w_raw & reset;
  assign MemW    = mem_w_raw & reset;
  assign FlagW   = flag_w_raw & {2{reset}};
  assign PCS     = (((Rd == 4'hF) & reg_w_raw) | branch_raw) & reset;

  assign ImmSrc = Op;
  assign RegSrc = {(Op == 2'b01), (Op == 2'b10)};

endmodule

// File: tb/tb_multicycle_decoder.sv
// Self-checking bench for multicycle_decoder: directed instructions plus
// random instructions compared cycle by cycle against a behavioural model
// that derives each cycle's outputs from the instruction class and step.
module tb_multicycle_decoder;

  logic       clk;
  logic       reset;
  logic [1:0] Op;
  logic [5:0] Funct;
  logic [3:0] Rd;
  logic       PCS, NextPC, RegW, MemW, IRWrite, AdrSrc, ALUSrcA;
  logic [1:0] FlagW, ResultSrc, ALUSrcB, ImmSrc, RegSrc, ALUControl;

  int unsigned errors = 0;
  int unsigned checks = 0;

  multicycle_decoder #(.STATE_W(4)) dut (
    .clk(clk), .reset(reset), .Op(Op), .Funct(Funct), .Rd(Rd),
    .PCS(PCS), .NextPC(NextPC), .RegW(RegW), .MemW(MemW), .FlagW(FlagW),
    .IRWrite(IRWrite), .AdrSrc(AdrSrc), .ResultSrc(ResultSrc),
    .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ImmSrc(ImmSrc),
    .RegSrc(RegSrc), .ALUControl(ALUControl)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h expected=%h (Op=%b Funct=%b Rd=%h)", tag, got, exp, Op, Funct, Rd);
    end
  endtask

  // Pack order: PCS NextPC RegW MemW FlagW IRWrite AdrSrc ResultSrc ALUSrcA ALUSrcB ImmSrc RegSrc ALUControl
  function automatic logic [18:0] observed();
    return {PCS, NextPC, RegW, MemW, FlagW, IRWrite, AdrSrc, ResultSrc,
            ALUSrcA, ALUSrcB, ImmSrc, RegSrc, ALUControl};
  endfunction

  // Instruction classes: 0 data-proc, 1 LDR, 2 STR, 3 branch, 4 undefined.
  function automatic int cls(input logic [1:0] op, input logic [5:0] f);
    if (op == 2'b00) return 0;
    if (op == 2'b01) return f[0] ? 1 : 2;
    if (op == 2'b10) return 3;
    return 4;
  endfunction

  function automatic int latency(input logic [1:0] op, input logic [5:0] f);
    int lat[5] = '{4, 5, 4, 3, 2};
    return lat[cls(op, f)];
  endfunction

  // Expected outputs for cycle 'step' of an instruction (0 = fetch).
  function automatic logic [18:0] model(input logic [1:0] op, input logic [5:0] f,
                                        input logic [3:0] rd, input int step, input bit in_reset);
    logic pcs = 0, npc = 0, rw = 0, mw = 0, irw = 0, adr = 0, srca = 0;
    logic [1:0] fw = 0, res = 0, srcb = 0, aluc = 0;
    int c = cls(op, f);
    if (step == 0) begin
      srca = 1; srcb = 2; res = 2; irw = 1; npc = 1;
    end else if (step == 1) begin
      srca = 1; srcb = 2; res = 2;
    end else if (step == 2) begin
      if (c == 1 || c == 2) srcb = 1;
      else if (c == 3) begin srcb = 1; res = 2; pcs = 1; end
      else if (c == 0) begin
        srcb = f[5] ? 2'd1 : 2'd0;
        case (f[4:1])
          4'd4:  begin aluc = 0; fw = {f[0], f[0]}; end
          4'd2:  begin aluc = 1; fw = {f[0], f[0]}; end
          4'd0:  begin aluc = 2; fw = {f[0], 1'b0}; end
          4'd12: begin aluc = 3; fw = {f[0], 1'b0}; end
          default: begin aluc = 0; fw = 0; end
        endcase
      end
    end else if (step == 3) begin
      if (c == 1) adr = 1;
      else if (c == 2) begin adr = 1; mw = 1; end
      else if (c == 0) begin rw = 1; pcs = (rd == 4'd15); end
    end else if (step == 4) begin
      res = 1; rw = 1; pcs = (rd == 4'd15);
    end
    if (in_reset) begin
      pcs = 0; npc = 0; rw = 0; mw = 0; fw = 0; irw = 0;
    end
    return {pcs, npc, rw, mw, fw, irw, adr, res, srca, srcb, op,
            op == 2'b01, op == 2'b10, aluc};
  endfunction

  // Runs one instruction starting in FETCH just after a falling edge.
  // abort_at >= 0 pulses reset after checking that step, leaving the DUT in FETCH.
  task automatic run_instr(input logic [1:0] op, input logic [5:0] f,
                           input logic [3:0] rd, input int abort_at, input string name);
    int lat = latency(op, f);
    Op = op; Funct = f; Rd = rd;
    for (int s = 0; s < lat; s++) begin
      if (s != 0) begin
        @(negedge clk);
      end
      #1;
      check($sformatf("%s_s%0d", name, s), 32'(observed()), 32'(model(op, f, rd, s, 1'b0)));
      check($sformatf("%s_one_write", name), 32'(RegW & MemW), 32'd0);
      if (s == abort_at) begin
        reset = 1'b0;
        #1;
        check($sformatf("%s_abort", name), 32'(observed()), 32'(model(op, f, rd, 0, 1'b1)));
        @(negedge clk);
        #1;
        check($sformatf("%s_abort_hold", name), 32'(observed()), 32'(model(op, f, rd, 0, 1'b1)));
        reset = 1'b1;
        return;
      end
    end
    @(negedge clk);
  endtask

  logic [5:0] cmds[4] = '{6'b001000, 6'b000100, 6'b000000, 6'b011000};

  initial begin
    reset = 1'b0; Op = 2'b00; Funct = 6'b0; Rd = 4'h0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      #1;
      check("reset_hold", 32'(observed()), 32'(model(Op, Funct, Rd, 0, 1'b1)));
    end
    reset = 1'b1;

    run_instr(2'b00, 6'b101001, 4'd3,  -1, "adds_imm");
    run_instr(2'b01, 6'b011001, 4'd15, -1, "ldr_pc");
    run_instr(2'b01, 6'b011000, 4'd15, -1, "str");
    run_instr(2'b10, 6'b100000, 4'd0,  -1, "branch");
    run_instr(2'b11, 6'b111111, 4'd15, -1, "undef");
    run_instr(2'b00, 6'b011000, 4'd15,  2, "orr_abort");
    run_instr(2'b00, 6'b000101, 4'd15, -1, "subs_reg_pc");
    run_instr(2'b00, 6'b101111, 4'd1,  -1, "unknown_cmd");

    for (int n = 0; n < 300; n++) begin
      logic [1:0] op;
      logic [5:0] f;
      logic [3:0] rd;
      int abort;
      op = 2'($urandom_range(0, 3));
      f  = 6'($urandom);
      if ($urandom_range(0, 1) == 1) f[4:1] = cmds[$urandom_range(0, 3)][4:1];
      rd = ($urandom_range(0, 3) == 0) ? 4'hF : 4'($urandom);
      abort = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, latency(op, f) - 1)) : -1;
      run_instr(op, f, rd, abort, "rand");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
